// File: rtl/sc_statemachine_jug.sv
// Moore control FSM for the sliding-player game: clear, load, shift and crash sequencing.
// Optional JUG_AUTOREPEAT_EN adds a hold-to-repeat counter in RELEASE_0.
module sc_statemachine_jug #(
    parameter int          DATAWIDTH     = 8,
    parameter logic [23:0] REPEAT_CYCLES = 24'd5000000
) (
    input  logic                 SC_STATEMACHINE_JUG_CLOCK_50,
    input  logic                 SC_STATEMACHINE_JUG_RESET_InHigh,
    input  logic                 SC_STATEMACHINE_JUG_left_InLow,
    input  logic                 SC_STATEMACHINE_JUG_right_InLow,
    input  logic                 SC_STATEMACHINE_JUG_crash_InLow,
    input  logic                 SC_STATEMACHINE_JUG_restart_InLow,
    input  logic [DATAWIDTH-1:0] SC_STATEMACHINE_JUG_data_InBUS,
    output logic                 SC_STATEMACHINE_JUG_clear_OutLow,
    output logic                 SC_STATEMACHINE_JUG_load0_OutLow,
    output logic                 SC_STATEMACHINE_JUG_load1_OutLow,
    output logic [1:0]           SC_STATEMACHINE_JUG_shiftselection_Out
);

    typedef enum logic [2:0] {
        RESET_0, START_0, CHECK_0, LEFT_0, RIGHT_0, RELEASE_0, CRASH_0, LOCK_0
    } stateT;

    stateT state, stateNext;

    logic leftPressed, rightPressed, crashActive, restartActive;
    logic leftOk, rightOk, bothReleased;
    logic repeatToLeft, repeatToRight;
    logic unusedBits;

    assign leftPressed   = ~SC_STATEMACHINE_JUG_left_InLow;
    assign rightPressed  = ~SC_STATEMACHINE_JUG_right_InLow;
    assign crashActive   = ~SC_STATEMACHINE_JUG_crash_InLow;
    assign restartActive = ~SC_STATEMACHINE_JUG_restart_InLow;
    assign bothReleased  = ~leftPressed & ~rightPressed;

    // A single press only; the player may not move past either edge of the register.
    assign leftOk  = leftPressed & ~rightPressed & ~SC_STATEMACHINE_JUG_data_InBUS[DATAWIDTH-1];
    assign rightOk = rightPressed & ~leftPressed & ~SC_STATEMACHINE_JUG_data_InBUS[0];

    assign unusedBits = ^{SC_STATEMACHINE_JUG_data_InBUS, REPEAT_CYCLES};

`ifdef JUG_AUTOREPEAT_EN
    logic [23:0] repeatCount;
    logic        repeatLeft;
    logic        holdSame, repeatFire;

    assign holdSame   = repeatLeft ? (leftPressed & ~rightPressed) : (rightPressed & ~leftPressed);
    assign repeatFire = holdSame && (repeatCount == REPEAT_CYCLES - 24'd1);
    assign repeatToLeft  = repeatFire & repeatLeft & ~SC_STATEMACHINE_JUG_data_InBUS[DATAWIDTH-1];
    assign repeatToRight = repeatFire & ~repeatLeft & ~SC_STATEMACHINE_JUG_data_InBUS[0];

    // Direction is latched while in LEFT_0/RIGHT_0 so RELEASE_0 knows which button to time.
    always_ff @(posedge SC_STATEMACHINE_JUG_CLOCK_50) begin
        if (SC_STATEMACHINE_JUG_RESET_InHigh) begin
            repeatCount <= '0;
            repeatLeft  <= 1'b0;
        end else begin
            if (state == LEFT_0)
                repeatLeft <= 1'b1;
            else if (state == RIGHT_0)
                repeatLeft <= 1'b0;

            if (state == RELEASE_0 && holdSame && !repeatFire)
                repeatCount <= repeatCount + 24'd1;
            else
                repeatCount <= '0;
        end
    end
`else
    assign repeatToLeft  = 1'b0;
    assign repeatToRight = 1'b0;
`endif

    always_ff @(posedge SC_STATEMACHINE_JUG_CLOCK_50) begin
        if (SC_STATEMACHINE_JUG_RESET_InHigh)
            state <= RESET_0;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            RESET_0:  stateNext = START_0;
            START_0:  stateNext = CHECK_0;
            CHECK_0: begin
                if (crashActive)
                    stateNext = CRASH_0;
                else if (leftOk)
                    stateNext = LEFT_0;
                else if (rightOk)
                    stateNext = RIGHT_0;
            end
            LEFT_0:   stateNext = RELEASE_0;
            RIGHT_0:  stateNext = RELEASE_0;
            RELEASE_0: begin
                if (crashActive)
                    stateNext = CRASH_0;
                else if (bothReleased)
                    stateNext = CHECK_0;
                else if (repeatToLeft)
                    stateNext = LEFT_0;
                else if (repeatToRight)
                    stateNext = RIGHT_0;
            end
            CRASH_0:  stateNext = LOCK_0;
            LOCK_0: begin
                if (restartActive)
                    stateNext = RESET_0;
            end
            default:  stateNext = RESET_0;
        endcase
    end

    always_comb begin
        SC_STATEMACHINE_JUG_clear_OutLow       = 1'b1;
        SC_STATEMACHINE_JUG_load0_OutLow       = 1'b1;
        SC_STATEMACHINE_JUG_load1_OutLow       = 1'b1;
        SC_STATEMACHINE_JUG_shiftselection_Out = 2'b00;
        case (state)
            RESET_0:  SC_STATEMACHINE_JUG_clear_OutLow       = 1'b0;
            START_0:  SC_STATEMACHINE_JUG_load0_OutLow       = 1'b0;
            LEFT_0:   SC_STATEMACHINE_JUG_shiftselection_Out = 2'b01;
            RIGHT_0:  SC_STATEMACHINE_JUG_shiftselection_Out = 2'b10;
            CRASH_0:  SC_STATEMACHINE_JUG_load1_OutLow       = 1'b0;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_sc_statemachine_jug.sv
// Directed bench for sc_statemachine_jug; outputs are sampled 1 time unit after each rising edge.
module tb_sc_statemachine_jug;

    logic       clk = 1'b0;
    logic       rst, left, right, crash, restart;
    logic [7:0] data;
    logic       clearO, load0O, load1O;
    logic [1:0] shiftO;
    logic [4:0] outs;

    int tests = 0;
    int fails = 0;

    localparam logic [4:0] O_IDLE  = 5'b11100;
    localparam logic [4:0] O_RESET = 5'b01100;
    localparam logic [4:0] O_START = 5'b10100;
    localparam logic [4:0] O_LEFT  = 5'b11101;
    localparam logic [4:0] O_RIGHT = 5'b11110;
    localparam logic [4:0] O_CRASH = 5'b11000;

    always #5 clk = ~clk;

    assign outs = {clearO, load0O, load1O, shiftO};

    sc_statemachine_jug #(
        .DATAWIDTH(8),
        .REPEAT_CYCLES(24'd4)
    ) dut (
        .SC_STATEMACHINE_JUG_CLOCK_50(clk),
        .SC_STATEMACHINE_JUG_RESET_InHigh(rst),
        .SC_STATEMACHINE_JUG_left_InLow(left),
        .SC_STATEMACHINE_JUG_right_InLow(right),
        .SC_STATEMACHINE_JUG_crash_InLow(crash),
        .SC_STATEMACHINE_JUG_restart_InLow(restart),
        .SC_STATEMACHINE_JUG_data_InBUS(data),
        .SC_STATEMACHINE_JUG_clear_OutLow(clearO),
        .SC_STATEMACHINE_JUG_load0_OutLow(load0O),
        .SC_STATEMACHINE_JUG_load1_OutLow(load1O),
        .SC_STATEMACHINE_JUG_shiftselection_Out(shiftO)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (outs !== O_RESET) begin
                fails++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", i, outs, O_RESET);
            end
        end
        rst = 1'b0;
        tests++;
        if (outs !== O_RESET) begin
            fails++;
            $display("FAIL reset_first_after_release: got %b expected %b", outs, O_RESET);
        end
        tick();
        tests++;
        if (outs !== O_START) begin
            fails++;
            $display("FAIL reset_start: got %b expected %b", outs, O_START);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (outs !== O_IDLE) begin
                fails++;
                $display("FAIL reset_check_idle %0d: got %b expected %b", i, outs, O_IDLE);
            end
        end
    endtask

    task automatic test_left_hold();
        int extra;
        int expExtra;
`ifdef JUG_AUTOREPEAT_EN
        expExtra = 1;
`else
        expExtra = 0;
`endif
        data = 8'b00001000;
        left = 1'b0;
        tick();
        tests++;
        if (outs !== O_LEFT) begin
            fails++;
            $display("FAIL left_first: got %b expected %b", outs, O_LEFT);
        end
        extra = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (shiftO !== 2'b00) extra++;
        end
        tests++;
        if (extra != expExtra) begin
            fails++;
            $display("FAIL left_held_extra_shifts: got %0d expected %0d", extra, expExtra);
        end
        left = 1'b1;
        tick();
        tests++;
        if (outs !== O_IDLE) begin
            fails++;
            $display("FAIL left_back_to_check: got %b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_boundary();
        int shifts;
        data = 8'b10000000;
        left = 1'b0;
        shifts = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (shiftO !== 2'b00) shifts++;
        end
        tests++;
        if (shifts != 0) begin
            fails++;
            $display("FAIL left_at_msb: got %0d shifts expected 0", shifts);
        end
        left = 1'b1;
        right = 1'b0;
        tick();
        tests++;
        if (outs !== O_RIGHT) begin
            fails++;
            $display("FAIL right_from_msb: got %b expected %b", outs, O_RIGHT);
        end
        tick();
        tests++;
        if (outs !== O_IDLE) begin
            fails++;
            $display("FAIL right_single_pulse: got %b expected %b", outs, O_IDLE);
        end
        right = 1'b1;
        tick();
        data = 8'b00000001;
        right = 1'b0;
        shifts = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (shiftO !== 2'b00) shifts++;
        end
        tests++;
        if (shifts != 0) begin
            fails++;
            $display("FAIL right_at_lsb: got %0d shifts expected 0", shifts);
        end
        right = 1'b1;
        tick();
        data = 8'b00001000;
    endtask

    task automatic test_both_buttons();
        int shifts;
        left = 1'b0;
        right = 1'b0;
        shifts = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (shiftO !== 2'b00) shifts++;
        end
        tests++;
        if (shifts != 0) begin
            fails++;
            $display("FAIL both_buttons: got %0d shifts expected 0", shifts);
        end
        left = 1'b1;
        right = 1'b1;
        tick();
    endtask

    task automatic test_hold_repeat();
        logic [11:0] mask;
        logic [11:0] expMask;
`ifdef JUG_AUTOREPEAT_EN
        expMask = 12'b0100_0010_0001;
`else
        expMask = 12'b0000_0000_0001;
`endif
        data = 8'b00010000;
        right = 1'b0;
        mask = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            mask[i] = (shiftO === 2'b10);
        end
        tests++;
        if (mask !== expMask) begin
            fails++;
            $display("FAIL right_hold_pattern: got %b expected %b", mask, expMask);
        end
        right = 1'b1;
        tick();
        tick();
        data = 8'b00001000;
    endtask

    task automatic test_crash_lock();
        left = 1'b0;
        crash = 1'b0;
        tick();
        tests++;
        if (outs !== O_CRASH) begin
            fails++;
            $display("FAIL crash_priority: got %b expected %b", outs, O_CRASH);
        end
        tick();
        tests++;
        if (outs !== O_IDLE) begin
            fails++;
            $display("FAIL crash_to_lock: got %b expected %b", outs, O_IDLE);
        end
        for (int i = 0; i < 4; i++) begin
            left  = i[0];
            right = ~i[0];
            tick();
            tests++;
            if (outs !== O_IDLE) begin
                fails++;
                $display("FAIL lock_ignores_inputs %0d: got %b expected %b", i, outs, O_IDLE);
            end
        end
        crash = 1'b1;
        left = 1'b1;
        right = 1'b1;
        restart = 1'b0;
        tick();
        tests++;
        if (outs !== O_RESET) begin
            fails++;
            $display("FAIL restart_clear: got %b expected %b", outs, O_RESET);
        end
        restart = 1'b1;
        tick();
        tests++;
        if (outs !== O_START) begin
            fails++;
            $display("FAIL restart_load0: got %b expected %b", outs, O_START);
        end
        tick();
    endtask

    task automatic test_release_crash();
        left = 1'b0;
        tick();
        tick();
        crash = 1'b0;
        tick();
        tests++;
        if (outs !== O_CRASH) begin
            fails++;
            $display("FAIL release_crash: got %b expected %b", outs, O_CRASH);
        end
        crash = 1'b1;
        left = 1'b1;
        tick();
        restart = 1'b0;
        tick();
        restart = 1'b1;
        tick();
        tick();
        tests++;
        if (outs !== O_IDLE) begin
            fails++;
            $display("FAIL release_crash_recover: got %b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_reset_mid_shift();
        left = 1'b0;
        tick();
        tests++;
        if (outs !== O_LEFT) begin
            fails++;
            $display("FAIL mid_shift_setup: got %b expected %b", outs, O_LEFT);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (outs !== O_RESET) begin
            fails++;
            $display("FAIL reset_during_left: got %b expected %b", outs, O_RESET);
        end
        rst = 1'b0;
        left = 1'b1;
        tick();
        tests++;
        if (outs !== O_START) begin
            fails++;
            $display("FAIL reset_mid_start: got %b expected %b", outs, O_START);
        end
        tick();
        tests++;
        if (outs !== O_IDLE) begin
            fails++;
            $display("FAIL reset_mid_check: got %b expected %b", outs, O_IDLE);
        end
    endtask

    initial begin
        rst = 1'b1;
        left = 1'b1;
        right = 1'b1;
        crash = 1'b1;
        restart = 1'b1;
        data = 8'b00001000;
        test_reset();
        test_left_hold();
        test_boundary();
        test_both_buttons();
        test_hold_repeat();
        test_crash_lock();
        test_release_crash();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
